// File: rtl/mon_commit_checker.sv
// Commit-stream checker for RVFI-style monitor channels: retirement order, halt discipline
// and forward progress, reported through a sticky first-error record.
module mon_commit_checker #(
    parameter int CHANNELS = 1,
    parameter int TIMEOUT  = 10000,
    parameter int CNT_W    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CHANNELS-1:0]    valid,
    input  logic [CHANNELS*64-1:0] order,
    input  logic [CHANNELS-1:0]    halt,
    output logic [CNT_W-1:0]       retired,
    output logic                   halted,
    output logic                   error,
    output logic [2:0]             err_code,
    output logic [63:0]            err_order
);

    localparam int N_W    = $clog2(CHANNELS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN,
        HALT,
        ERR
    } state_t;

    typedef enum logic [2:0] {
        E_NONE    = 3'd0,
        E_ORDER   = 3'd1,
        E_GAP     = 3'd2,
        E_HALT    = 3'd3,
        E_TIMEOUT = 3'd4,
        E_X       = 3'd5
    } err_t;

    state_t            state;
    logic [63:0]       exp_order;
    logic [IDLE_W-1:0] idle_cnt;

    logic [N_W-1:0]    n;
    logic              gap;
    logic              ord_err;
    logic              halt_err;
    logic              halt_seen;
    logic              timeout;
    logic              x_err;
    err_t              nxt_code;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        n         = '0;
        ord_err   = 1'b0;
        halt_err  = 1'b0;
        halt_seen = 1'b0;
        nxt_code  = E_NONE;

        for (int c = 0; c < CHANNELS; c++) begin
            if (valid[c]) begin
                n = n + N_W'(1);
                if (order[64*c +: 64] != exp_order + 64'(c))
                    ord_err = 1'b1;
                if (halt[c]) begin
                    halt_seen = 1'b1;
                    if ((valid >> (c + 1)) != '0)
                        halt_err = 1'b1;
                end
            end
        end

        // A contiguous run from channel 0 is all-ones, so adding one clears every set bit.
        gap     = (({1'b0, valid} & ({1'b0, valid} + 1'b1)) != '0);
        timeout = (n == '0) && (idle_cnt == IDLE_W'(TIMEOUT - 1));
        // X/Z screen on valid; only meaningful in a four-state simulator.
        x_err   = $isunknown(valid);

        case (state)
            RUN: begin
                if (x_err)         nxt_code = E_X;
                else if (gap)      nxt_code = E_GAP;
                else if (ord_err)  nxt_code = E_ORDER;
                else if (halt_err) nxt_code = E_HALT;
                else if (timeout)  nxt_code = E_TIMEOUT;
            end
            HALT: begin
                if (x_err)              nxt_code = E_X;
                else if (valid != '0)   nxt_code = E_HALT;
            end
            default: nxt_code = E_NONE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            exp_order <= '0;
            idle_cnt  <= '0;
            retired   <= '0;
            halted    <= 1'b0;
            error     <= 1'b0;
            err_code  <= 3'd0;
            err_order <= '0;
        end else if (state != ERR && nxt_code != E_NONE) begin
            error     <= 1'b1;
            err_code  <= nxt_code;
            err_order <= exp_order;
            state     <= ERR;
        end else begin
            case (state)
                RUN: begin
                    exp_order <= exp_order + 64'(n);
                    retired   <= retired + CNT_W'(n);
                    idle_cnt  <= (n == '0) ? idle_cnt + IDLE_W'(1) : '0;
                    if (halt_seen) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mon_commit_checker.sv
// Scoreboard bench for mon_commit_checker: a 1-channel and a 2-channel instance, both with
// TIMEOUT=16, driven by directed vectors with hand-computed expectations.
module tb_mon_commit_checker;

    logic         clk;
    logic         rst;

    logic         v1;
    logic [63:0]  o1;
    logic         h1;
    logic [63:0]  r1;
    logic         hd1;
    logic         e1;
    logic [2:0]   c1;
    logic [63:0]  eo1;

    logic [1:0]   v2;
    logic [127:0] o2;
    logic [1:0]   h2;
    logic [63:0]  r2;
    logic         hd2;
    logic         e2;
    logic [2:0]   c2;
    logic [63:0]  eo2;

    mon_commit_checker #(.CHANNELS(1), .TIMEOUT(16), .CNT_W(64)) u_ch1 (
        .clk(clk), .rst(rst), .valid(v1), .order(o1), .halt(h1),
        .retired(r1), .halted(hd1), .error(e1), .err_code(c1), .err_order(eo1)
    );

    mon_commit_checker #(.CHANNELS(2), .TIMEOUT(16), .CNT_W(64)) u_ch2 (
        .clk(clk), .rst(rst), .valid(v2), .order(o2), .halt(h2),
        .retired(r2), .halted(hd2), .error(e2), .err_code(c2), .err_order(eo2)
    );

    typedef struct {
        int          inst;
        bit          asy;
        int unsigned cyc;
        string       name;
        logic [63:0] ret;
        logic        hlt;
        logic        err;
        logic [2:0]  code;
        logic [63:0] eord;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc;
    int          vectors;
    int          miscompares;
    event        async_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input exp_t e);
        logic [63:0] ret;
        logic        hlt;
        logic        err;
        logic [2:0]  code;
        logic [63:0] eord;
        if (e.inst == 1) begin
            ret = r1; hlt = hd1; err = e1; code = c1; eord = eo1;
        end else begin
            ret = r2; hlt = hd2; err = e2; code = c2; eord = eo2;
        end
        vectors++;
        if (ret !== e.ret || hlt !== e.hlt || err !== e.err || code !== e.code || eord !== e.eord) begin
            miscompares++;
            $display("FAIL %s (ch%0d): got retired=%0d halted=%0b error=%0b err_code=%0d err_order=%0d, want retired=%0d halted=%0b error=%0b err_code=%0d err_order=%0d",
                     e.name, e.inst, ret, hlt, err, code, eord, e.ret, e.hlt, e.err, e.code, e.eord);
        end
    endtask

    // Clocked monitor: compares entries that fall due on this edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        while (q.size() > 0 && !q[0].asy && q[0].cyc == cyc) begin
            e = q.pop_front();
            check(e);
        end
    end

    // Asynchronous monitor: compares entries queued for an immediate (reset) check.
    always @(async_ev) begin
        exp_t e;
        #1;
        while (q.size() > 0 && q[0].asy) begin
            e = q.pop_front();
            check(e);
        end
    end

    task automatic push(input int inst, input bit asy, input string name, input logic [63:0] ret,
                        input logic hlt, input logic err, input logic [2:0] code, input logic [63:0] eord);
        exp_t e;
        e.inst = inst; e.asy = asy; e.cyc = cyc + 1; e.name = name;
        e.ret = ret; e.hlt = hlt; e.err = err; e.code = code; e.eord = eord;
        q.push_back(e);
    endtask

    task automatic expect_next(input int inst, input string name, input logic [63:0] ret,
                               input logic hlt, input logic err, input logic [2:0] code, input logic [63:0] eord);
        push(inst, 1'b0, name, ret, hlt, err, code, eord);
    endtask

    task automatic expect_reset_now(input string name);
        push(1, 1'b1, name, 0, 1'b0, 1'b0, 3'd0, 0);
        push(2, 1'b1, name, 0, 1'b0, 1'b0, 3'd0, 0);
        -> async_ev;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b0;
        v1 = 1'b0; o1 = '0; h1 = 1'b0;
        v2 = 2'b00; o2 = '0; h2 = 2'b00;
        expect_reset_now(name);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step1(input logic v, input logic [63:0] o, input logic h);
        @(negedge clk);
        v1 = v; o1 = o; h1 = h;
    endtask

    task automatic step2(input logic [1:0] v, input logic [63:0] o_hi, input logic [63:0] o_lo,
                         input logic [1:0] h);
        @(negedge clk);
        v2 = v; o2 = {o_hi, o_lo}; h2 = h;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want scenario completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        v1 = 1'b0; o1 = '0; h1 = 1'b0;
        v2 = 2'b00; o2 = '0; h2 = 2'b00;

        // CH1: in-order commits 0,1,2.
        do_reset("reset_state");
        for (int i = 0; i < 3; i++) begin
            step1(1'b1, 64'(i), 1'b0);
            expect_next(1, "inorder", 64'(i + 1), 1'b0, 1'b0, 3'd0, 0);
        end

        // CH1: 0,1 then 3 -> order error at exp 2; then error is terminal.
        do_reset("reset_b");
        step1(1'b1, 0, 1'b0); expect_next(1, "ord_c0", 1, 1'b0, 1'b0, 3'd0, 0);
        step1(1'b1, 1, 1'b0); expect_next(1, "ord_c1", 2, 1'b0, 1'b0, 3'd0, 0);
        step1(1'b1, 3, 1'b0); expect_next(1, "ord_err", 2, 1'b0, 1'b1, 3'd1, 2);
        step1(1'b1, 2, 1'b0); expect_next(1, "err_hold", 2, 1'b0, 1'b1, 3'd1, 2);

        // CH2: paired commits, idle, single commit, then a gap.
        do_reset("reset_c");
        step2(2'b11, 1, 0, 2'b00); expect_next(2, "pair01", 2, 1'b0, 1'b0, 3'd0, 0);
        step2(2'b11, 3, 2, 2'b00); expect_next(2, "pair23", 4, 1'b0, 1'b0, 3'd0, 0);
        step2(2'b00, 0, 0, 2'b00); expect_next(2, "idle2", 4, 1'b0, 1'b0, 3'd0, 0);
        step2(2'b11, 5, 4, 2'b00); expect_next(2, "pair45", 6, 1'b0, 1'b0, 3'd0, 0);
        step2(2'b01, 0, 6, 2'b00); expect_next(2, "single6", 7, 1'b0, 1'b0, 3'd0, 0);
        step2(2'b10, 8, 0, 2'b00); expect_next(2, "gap", 7, 1'b0, 1'b1, 3'd2, 7);

        // CH2: order error outranks halt misplacement in the same cycle.
        do_reset("reset_d");
        step2(2'b11, 1, 9, 2'b01); expect_next(2, "prio_ord_halt", 0, 1'b0, 1'b1, 3'd1, 0);

        // CH2: halt on ch0 with ch1 also committing.
        do_reset("reset_e");
        step2(2'b11, 1, 0, 2'b01); expect_next(2, "halt_misplaced", 0, 1'b0, 1'b1, 3'd3, 0);

        // CH2: legal halt on the youngest channel, then a commit after halt.
        do_reset("reset_f");
        step2(2'b11, 1, 0, 2'b10); expect_next(2, "halt_top", 2, 1'b1, 1'b0, 3'd0, 0);
        step2(2'b00, 0, 0, 2'b00); expect_next(2, "halt_idle", 2, 1'b1, 1'b0, 3'd0, 0);
        step2(2'b01, 0, 2, 2'b00); expect_next(2, "after_halt2", 2, 1'b1, 1'b1, 3'd3, 2);

        // CH1: halt on order 7, then another commit.
        do_reset("reset_g");
        for (int i = 0; i < 8; i++) begin
            step1(1'b1, 64'(i), i == 7);
            expect_next(1, "to_halt", 64'(i + 1), i == 7, 1'b0, 3'd0, 0);
        end
        step1(1'b1, 8, 1'b0); expect_next(1, "after_halt1", 8, 1'b1, 1'b1, 3'd3, 8);

        // CH1: halted checker never times out.
        do_reset("reset_h");
        step1(1'b1, 0, 1'b1); expect_next(1, "halt0", 1, 1'b1, 1'b0, 3'd0, 0);
        for (int k = 1; k <= 20; k++) begin
            step1(1'b0, 0, 1'b0);
            if (k == 20) expect_next(1, "halt_no_timeout", 1, 1'b1, 1'b0, 3'd0, 0);
        end

        // CH1: one commit then 16 idle cycles -> timeout on the 16th.
        do_reset("reset_i");
        step1(1'b1, 0, 1'b0); expect_next(1, "to_commit", 1, 1'b0, 1'b0, 3'd0, 0);
        for (int k = 1; k <= 16; k++) begin
            step1(1'b0, 0, 1'b0);
            if (k == 15) expect_next(1, "idle15", 1, 1'b0, 1'b0, 3'd0, 0);
            if (k == 16) expect_next(1, "timeout", 1, 1'b0, 1'b1, 3'd4, 1);
        end

        // Mid-cycle async reset clears the latched error, then order 0 is accepted.
        @(posedge clk);
        #2;
        rst = 1'b0;
        expect_reset_now("async_reset");
        @(negedge clk);
        rst = 1'b1;
        step1(1'b1, 0, 1'b0); expect_next(1, "post_reset", 1, 1'b0, 1'b0, 3'd0, 0);

        step1(1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            miscompares++;
            $display("FAIL %s (ch%0d): got no comparison, want one at cycle %0d", e.name, e.inst, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
